// File: rtl/clock_core_v2_if.sv
// Display-side bus of clock_core_v2: time outputs plus the strobe/ack update handshake.
interface clock_core_v2_if;
    logic [4:0] o_hours;
    logic [4:0] o_disp_hours;
    logic       o_pm;
    logic [5:0] o_minutes;
    logic [5:0] o_seconds;
    logic       o_display_stb;
    logic       o_write_config;
    logic       i_display_ack;

    modport master (
        output o_hours, o_disp_hours, o_pm, o_minutes, o_seconds,
        output o_display_stb, o_write_config,
        input  i_display_ack
    );

    modport slave (
        input  o_hours, o_disp_hours, o_pm, o_minutes, o_seconds,
        input  o_display_stb, o_write_config,
        output i_display_ack
    );
endinterface

// File: rtl/clock_core_v2.sv
// Timekeeping core: refclk sync/prescale, HH:MM:SS with set modes, 12h display,
// alarm timer and the display-update request FSM.
module clock_core_v2 #(
    parameter int unsigned REFCLK_DIV   = 32768,
    parameter int unsigned SLOW_SET_DIV = 16384,
    parameter int unsigned FAST_SET_DIV = 4096,
    parameter int unsigned ALARM_SECS   = 60
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    input  logic        i_refclk,
    input  logic        i_fast_set,
    input  logic        i_set_hours,
    input  logic        i_set_minutes,
    input  logic        i_mode_12h,
    input  logic        i_alarm_en,
    input  logic [4:0]  i_alarm_hours,
    input  logic [5:0]  i_alarm_minutes,
    output logic        o_alarm,
    clock_core_v2_if.master bus
);
    localparam int unsigned REF_W  = (REFCLK_DIV   > 1) ? $clog2(REFCLK_DIV)   : 1;
    localparam int unsigned SLOW_W = (SLOW_SET_DIV > 1) ? $clog2(SLOW_SET_DIV) : 1;
    localparam int unsigned FAST_W = (FAST_SET_DIV > 1) ? $clog2(FAST_SET_DIV) : 1;
    localparam int unsigned ALM_W  = $clog2(ALARM_SECS + 1);

    typedef enum logic [1:0] {CFG_REQ, TIME_REQ, IDLE} disp_state_e;

    logic              refclk_meta_q, refclk_sync_q, refclk_prev_q, tick_q;
    logic [REF_W-1:0]  cnt_1hz_q,  cnt_1hz_d;
    logic [SLOW_W-1:0] cnt_slow_q, cnt_slow_d;
    logic [FAST_W-1:0] cnt_fast_q, cnt_fast_d;
    logic [4:0]        hours_q,   hours_d;
    logic [5:0]        minutes_q, minutes_d;
    logic [5:0]        seconds_q, seconds_d;
    logic              pm_q;
    logic              alarm_q,   alarm_d;
    logic [ALM_W-1:0]  alarm_cnt_q, alarm_cnt_d;
    logic              mode_prev_q, set_h_prev_q, set_m_prev_q;
    disp_state_e       state_q, state_d;
    logic              pending_q, pending_d;
    logic              stb_q, stb_d, cfg_q, cfg_d;

    logic set_mode, stb_1hz, stb_slow, stb_fast, set_stb;
    logic alarm_hit, input_edge, disp_event, acked;
    logic [4:0] disp_hours_c;

    assign set_mode = i_set_hours | i_set_minutes;
    assign stb_1hz  = tick_q & ~set_mode & (cnt_1hz_q == REF_W'(REFCLK_DIV - 1));
    assign stb_slow = tick_q & (cnt_slow_q == SLOW_W'(SLOW_SET_DIV - 1));
    assign stb_fast = tick_q & (cnt_fast_q == FAST_W'(FAST_SET_DIV - 1));
    assign set_stb  = i_fast_set ? stb_fast : stb_slow;

    // Prescalers: the 1 Hz count is parked at 0 in set mode so a run starts on a full second
    always_comb begin
        cnt_1hz_d  = cnt_1hz_q;
        cnt_slow_d = cnt_slow_q;
        cnt_fast_d = cnt_fast_q;
        if (set_mode)    cnt_1hz_d = '0;
        else if (tick_q) cnt_1hz_d = stb_1hz ? '0 : cnt_1hz_q + REF_W'(1);
        if (tick_q) begin
            cnt_slow_d = stb_slow ? '0 : cnt_slow_q + SLOW_W'(1);
            cnt_fast_d = stb_fast ? '0 : cnt_fast_q + FAST_W'(1);
        end
    end

    // Time register: independent hour/minute stepping in set mode, full carry chain in run mode
    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        if (set_mode) begin
            seconds_d = 6'd0;
            if (set_stb && i_set_hours)   hours_d   = (hours_q == 5'd23)   ? 5'd0 : hours_q + 5'd1;
            if (set_stb && i_set_minutes) minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
        end else if (stb_1hz) begin
            if (seconds_q != 6'd59) begin
                seconds_d = seconds_q + 6'd1;
            end else begin
                seconds_d = 6'd0;
                if (minutes_q != 6'd59) begin
                    minutes_d = minutes_q + 6'd1;
                end else begin
                    minutes_d = 6'd0;
                    hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                end
            end
        end
    end

    assign alarm_hit = stb_1hz & i_alarm_en & (hours_d == i_alarm_hours)
                     & (minutes_d == i_alarm_minutes) & (seconds_d == 6'd0);

    always_comb begin
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;
        if (!i_alarm_en) begin
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
        end else if (alarm_hit) begin
            alarm_d     = 1'b1;
            alarm_cnt_d = ALM_W'(ALARM_SECS);
        end else if (stb_1hz && alarm_q) begin
            alarm_cnt_d = alarm_cnt_q - ALM_W'(1);
            if (alarm_cnt_q == ALM_W'(1)) alarm_d = 1'b0;
        end
    end

    // Datapath registers; the synchroniser pair runs freely, everything else honours i_en
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            refclk_meta_q <= 1'b0;
            refclk_sync_q <= 1'b0;
            refclk_prev_q <= 1'b0;
            tick_q        <= 1'b0;
            cnt_1hz_q     <= '0;
            cnt_slow_q    <= '0;
            cnt_fast_q    <= '0;
            hours_q       <= 5'd0;
            minutes_q     <= 6'd0;
            seconds_q     <= 6'd0;
            pm_q          <= 1'b0;
            alarm_q       <= 1'b0;
            alarm_cnt_q   <= '0;
            mode_prev_q   <= 1'b0;
            set_h_prev_q  <= 1'b0;
            set_m_prev_q  <= 1'b0;
        end else begin
            refclk_meta_q <= i_refclk;
            refclk_sync_q <= refclk_meta_q;
            tick_q        <= i_en & refclk_sync_q & ~refclk_prev_q;
            if (i_en) begin
                refclk_prev_q <= refclk_sync_q;
                cnt_1hz_q     <= cnt_1hz_d;
                cnt_slow_q    <= cnt_slow_d;
                cnt_fast_q    <= cnt_fast_d;
                hours_q       <= hours_d;
                minutes_q     <= minutes_d;
                seconds_q     <= seconds_d;
                pm_q          <= (hours_d >= 5'd12);
                alarm_q       <= alarm_d;
                alarm_cnt_q   <= alarm_cnt_d;
                mode_prev_q   <= i_mode_12h;
                set_h_prev_q  <= i_set_hours;
                set_m_prev_q  <= i_set_minutes;
            end
        end
    end

    assign input_edge = (i_mode_12h ^ mode_prev_q) | (i_set_hours ^ set_h_prev_q)
                      | (i_set_minutes ^ set_m_prev_q);
    assign disp_event = stb_1hz | (set_mode & set_stb) | input_edge;
    assign acked      = bus.i_display_ack & stb_q;

    // Display request FSM: events arriving mid-request coalesce into one follow-up request
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            CFG_REQ: begin
                if (acked) begin
                    state_d   = TIME_REQ;
                    pending_d = 1'b0;
                end else if (disp_event) begin
                    pending_d = 1'b1;
                end
            end
            TIME_REQ: begin
                if (acked) begin
                    state_d   = (pending_q || disp_event) ? TIME_REQ : IDLE;
                    pending_d = 1'b0;
                end else if (disp_event) begin
                    pending_d = 1'b1;
                end
            end
            IDLE: begin
                if (disp_event) state_d = TIME_REQ;
            end
            default: state_d = CFG_REQ;
        endcase
        stb_d = (state_d != IDLE);
        cfg_d = (state_d == CFG_REQ);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= CFG_REQ;
            pending_q <= 1'b0;
            stb_q     <= 1'b0;
            cfg_q     <= 1'b0;
        end else if (i_en) begin
            state_q   <= state_d;
            pending_q <= pending_d;
            stb_q     <= stb_d;
            cfg_q     <= cfg_d;
        end
    end

    always_comb begin
        disp_hours_c = hours_q;
        if (hours_q == 5'd0)       disp_hours_c = 5'd12;
        else if (hours_q > 5'd12)  disp_hours_c = hours_q - 5'd12;
    end

    assign bus.o_hours        = hours_q;
    assign bus.o_disp_hours   = i_mode_12h ? disp_hours_c : hours_q;
    assign bus.o_pm           = pm_q;
    assign bus.o_minutes      = minutes_q;
    assign bus.o_seconds      = seconds_q;
    assign bus.o_display_stb  = stb_q;
    assign bus.o_write_config = cfg_q;
    assign o_alarm            = alarm_q;
endmodule

// File: tb/tb_clock_core_v2.sv
// Randomised self-checking bench for clock_core_v2 against a seconds-of-day reference model.
module tb_clock_core_v2;
    localparam int RDIV = 4, SDIV = 8, FDIV = 2, ASECS = 3;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, refclk = 1'b0;
    logic fast = 1'b0, set_h = 1'b0, set_m = 1'b0, mode12 = 1'b0, aen = 1'b0;
    logic [4:0] ah = 5'd0;
    logic [5:0] am = 6'd0;
    logic alarm;
    logic ack = 1'b0;

    clock_core_v2_if bus ();
    assign bus.i_display_ack = ack;

    clock_core_v2 #(.REFCLK_DIV(RDIV), .SLOW_SET_DIV(SDIV), .FAST_SET_DIV(FDIV), .ALARM_SECS(ASECS)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_refclk(refclk),
        .i_fast_set(fast), .i_set_hours(set_h), .i_set_minutes(set_m), .i_mode_12h(mode12),
        .i_alarm_en(aen), .i_alarm_hours(ah), .i_alarm_minutes(am),
        .o_alarm(alarm), .bus(bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    // Reference model: time as seconds of day, prescalers as plain edge counts
    int m_t = 0, m_c1 = 0, m_cs = 0, m_cf = 0, m_acnt = 0;
    bit m_alarm = 1'b0;
    int exp_txn = 0;
    // Display driver model
    int txn_cnt = 0, cfg_cnt = 0, ack_grant = 0, ack_used = 0, ack_delay = 2;
    bit ack_auto = 1'b1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Driver side: acks each request after ack_delay cycles (auto) or once per grant
    initial forever begin
        @(negedge clk);
        if (ack) begin
            ack = 1'b0;
        end else if (rst_n && bus.o_display_stb && (ack_auto || ack_grant != ack_used)) begin
            if (!ack_auto) ack_used++;
            repeat (ack_delay) @(negedge clk);
            ack = 1'b1;
            txn_cnt++;
            if (bus.o_write_config) cfg_cnt++;
        end
    end

    task automatic model_step();
        bit sstb;
        int h, mi;
        m_cs = (m_cs + 1) % SDIV;
        m_cf = (m_cf + 1) % FDIV;
        sstb = fast ? (m_cf == 0) : (m_cs == 0);
        if (set_h || set_m) begin
            if (sstb) begin
                h  = m_t / 3600;
                mi = (m_t / 60) % 60;
                if (set_h) h  = (h + 1) % 24;
                if (set_m) mi = (mi + 1) % 60;
                m_t = h * 3600 + mi * 60;
                exp_txn++;
            end
        end else begin
            m_c1 = (m_c1 + 1) % RDIV;
            if (m_c1 == 0) begin
                m_t = (m_t + 1) % 86400;
                exp_txn++;
                if (aen && m_t == int'(ah) * 3600 + int'(am) * 60) begin
                    m_alarm = 1'b1;
                    m_acnt  = ASECS;
                end else if (m_alarm) begin
                    m_acnt--;
                    if (m_acnt == 0) m_alarm = 1'b0;
                end
            end
        end
    endtask

    task automatic check_state(input string tag);
        int h, mi, s, d;
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        s  = m_t % 60;
        d  = mode12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
        check_eq({tag, ".hours"},   int'(bus.o_hours), h);
        check_eq({tag, ".minutes"}, int'(bus.o_minutes), mi);
        check_eq({tag, ".seconds"}, int'(bus.o_seconds), s);
        check_eq({tag, ".disp"},    int'(bus.o_disp_hours), d);
        check_eq({tag, ".pm"},      int'(bus.o_pm), (h >= 12) ? 1 : 0);
        check_eq({tag, ".alarm"},   int'(alarm), int'(m_alarm));
        if (ack_auto) check_eq({tag, ".txn"}, txn_cnt, exp_txn);
    endtask

    task automatic refclk_edge();
        @(negedge clk);
        refclk = 1'b1;
        repeat (6) @(negedge clk);
        refclk = 1'b0;
        repeat (6) @(negedge clk);
        if (en) model_step();
    endtask

    task automatic apply(input bit f, input bit sh, input bit sm, input bit md,
                         input bit ae, input int ahh, input int amm);
        @(negedge clk);
        if ((sh != set_h) || (sm != set_m) || (md != mode12)) exp_txn++;
        fast = f; set_h = sh; set_m = sm; mode12 = md; aen = ae;
        ah = 5'(ahh); am = 6'(amm);
        if (sh || sm) begin
            m_t  = m_t - (m_t % 60);
            m_c1 = 0;
        end
        if (!ae) begin
            m_alarm = 1'b0;
            m_acnt  = 0;
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic goto_time(input int h, input int mi);
        apply(1'b1, 1'b1, 1'b0, mode12, aen, int'(ah), int'(am));
        for (int k = 0; k < 100 && (m_t / 3600) != h; k++) begin
            refclk_edge();
            check_state("goto_h");
        end
        apply(1'b1, 1'b0, 1'b1, mode12, aen, int'(ah), int'(am));
        for (int k = 0; k < 200 && ((m_t / 60) % 60) != mi; k++) begin
            refclk_edge();
            check_state("goto_m");
        end
        apply(1'b0, 1'b0, 1'b0, mode12, aen, int'(ah), int'(am));
        check_eq("goto.hours", int'(bus.o_hours), h);
        check_eq("goto.minutes", int'(bus.o_minutes), mi);
    endtask

    task automatic run_until(input int target, input int max_edges);
        for (int k = 0; k < max_edges && m_t != target; k++) begin
            refclk_edge();
            check_state("run");
        end
        check_eq("run_until.time", int'(bus.o_hours) * 3600 + int'(bus.o_minutes) * 60 + int'(bus.o_seconds), target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hl[5], dl[5], pl[5];
        int h0, mi0, exp_save, cfg_save;
        hl = '{0, 11, 12, 13, 23};
        dl = '{12, 11, 12, 1, 11};
        pl = '{0, 0, 1, 1, 1};

        // Reset values, then config + time transactions
        repeat (3) @(negedge clk);
        check_eq("rst.hours", int'(bus.o_hours), 0);
        check_eq("rst.seconds", int'(bus.o_seconds), 0);
        check_eq("rst.stb", int'(bus.o_display_stb), 0);
        check_eq("rst.cfg", int'(bus.o_write_config), 0);
        check_eq("rst.alarm", int'(alarm), 0);
        check_eq("rst.pm", int'(bus.o_pm), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("boot.stb", int'(bus.o_display_stb), 1);
        check_eq("boot.cfg", int'(bus.o_write_config), 1);
        repeat (30) @(negedge clk);
        exp_txn = 2;
        check_eq("boot.txn", txn_cnt, 2);
        check_eq("boot.cfg_txn", cfg_cnt, 1);
        check_eq("boot.idle", int'(bus.o_display_stb), 0);

        // Midnight rollover
        goto_time(23, 59);
        run_until(86399, 300);
        check_eq("wrap.pm_before", int'(bus.o_pm), 1);
        run_until(0, 8);
        check_eq("wrap.pm_after", int'(bus.o_pm), 0);
        check_eq("wrap.hours", int'(bus.o_hours), 0);

        // Fast hour set: 24 steps return to the start
        h0 = int'(bus.o_hours);
        mi0 = int'(bus.o_minutes);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (48) begin
            refclk_edge();
            check_state("fastset");
            check_eq("fastset.sec0", int'(bus.o_seconds), 0);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check_eq("fastset.hours", int'(bus.o_hours), h0);
        check_eq("fastset.minutes", int'(bus.o_minutes), mi0);

        // 12-hour display sweep
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            goto_time(hl[i], int'(bus.o_minutes));
            check_eq("h12.disp", int'(bus.o_disp_hours), dl[i]);
            check_eq("h12.pm", int'(bus.o_pm), pl[i]);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // Alarm at 00:01 for ASECS seconds, then an early disable at 00:02:01
        goto_time(0, 0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            run_until(60 + k, 300);
            check_eq("alarm.window", int'(alarm), (k < 3) ? 1 : 0);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 2);
        run_until(121, 300);
        check_eq("alarm2.on", int'(alarm), 1);
        @(negedge clk);
        aen = 1'b0;
        m_alarm = 1'b0;
        m_acnt = 0;
        @(negedge clk);
        check_eq("alarm2.drop", int'(alarm), 0);
        repeat (8) @(negedge clk);

        // Held ack: three ticks coalesce into one extra transaction
        ack_auto = 1'b0;
        exp_save = exp_txn;
        repeat (12) begin
            refclk_edge();
            check_state("hold");
        end
        check_eq("hold.stb", int'(bus.o_display_stb), 1);
        check_eq("hold.cfg", int'(bus.o_write_config), 0);
        ack_grant++;
        repeat (10) @(negedge clk);
        check_eq("hold.retrigger", int'(bus.o_display_stb), 1);
        ack_grant++;
        repeat (10) @(negedge clk);
        check_eq("hold.idle", int'(bus.o_display_stb), 0);
        exp_txn = exp_save + 2;
        check_eq("hold.txn", txn_cnt, exp_txn);

        // Reset in the middle of a pending request
        repeat (4) refclk_edge();
        check_eq("midrst.pending_stb", int'(bus.o_display_stb), 1);
        cfg_save = cfg_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst.stb", int'(bus.o_display_stb), 0);
        check_eq("midrst.hours", int'(bus.o_hours), 0);
        check_eq("midrst.minutes", int'(bus.o_minutes), 0);
        check_eq("midrst.seconds", int'(bus.o_seconds), 0);
        m_t = 0; m_c1 = 0; m_cs = 0; m_cf = 0; m_alarm = 1'b0; m_acnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ack_auto = 1'b1;
        repeat (30) @(negedge clk);
        exp_txn = exp_txn + 1;
        check_eq("reboot.cfg_txn", cfg_cnt, cfg_save + 1);
        check_eq("reboot.idle", int'(bus.o_display_stb), 0);
        check_state("reboot");

        // Disabled core ignores a refclk edge
        en = 1'b0;
        refclk_edge();
        en = 1'b1;
        repeat (4) @(negedge clk);
        check_state("disabled");

        // Randomised mix of run and set periods
        for (int it = 0; it < 120; it++) begin
            ack_delay = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                int th, tm;
                th = (m_t / 3600);
                tm = ((m_t / 60) % 60 + 1) % 60;
                if ($urandom_range(0, 1) == 0) begin
                    th = int'($urandom_range(0, 23));
                    tm = int'($urandom_range(0, 59));
                end
                apply(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), th, tm);
                check_state("rnd_in");
            end else begin
                repeat ($urandom_range(1, 8)) begin
                    refclk_edge();
                    check_state("rnd");
                end
            end
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (20) @(negedge clk);
        check_eq("final.idle", int'(bus.o_display_stb), 0);
        check_state("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/clock_core_v2.md
Name: clock_core_v2

Overview:
Parametrised second-generation timekeeping core for the 7-segment clock. It covers:
- refclk synchronisation and prescaling;
- the hours/minutes/seconds register with fast/slow set;
- selectable 12/24-hour display format;
- an alarm comparator;
- the display-update request FSM.

It drives the MAX7219 output wrapper through a strobe/ack handshake, and sits between the debounced button inputs and the display driver.

Parameters:
- REFCLK_DIV, 32768: refclk rising edges per second.
- SLOW_SET_DIV, 16384: refclk edges per slow set strobe (2 Hz).
- FAST_SET_DIV, 4096: refclk edges per fast set strobe (8 Hz).
- ALARM_SECS, 60: seconds o_alarm stays asserted once triggered.

Ports:
- i_clk  in  1  system clock (~10 MHz)
- i_reset_n  in  1  reset
- i_en  in  1  enable; 0 freezes all counters, the FSM and the synchroniser edge detect
- i_refclk  in  1  32.768 kHz reference clock, asynchronous to i_clk
- i_fast_set  in  1  debounced; 1 selects the fast set rate
- i_set_hours  in  1  debounced; set hours
- i_set_minutes  in  1  debounced; set minutes
- i_mode_12h  in  1  1 selects 12-hour display format
- i_alarm_en  in  1  alarm enable
- i_alarm_hours  in  5  alarm hour, 0-23
- i_alarm_minutes  in  6  alarm minute, 0-59
- o_hours  out  5  internal hour, 0-23
- o_disp_hours  out  5  displayed hour: 0-23, or 1-12 in 12h mode
- o_pm  out  1  1 when o_hours >= 12
- o_minutes  out  6  0-59
- o_seconds  out  6  0-59
- o_alarm  out  1  alarm active
- o_display_stb  out  1  display update request
- i_display_ack  in  1  one-cycle ack from the display driver
- o_write_config  out  1  qualifies the request as a MAX7219 config write

Behaviour:
Clock and reset:
- One clock, i_clk. Reset i_reset_n is asynchronous and active-low. All flops clear on reset.
- Reset values: time 00:00:00, o_pm=0, o_alarm=0, o_display_stb=0, o_write_config=0, all prescalers 0.

Refclk path:
- i_refclk passes through a 2-flop synchroniser plus a rising-edge detect.
- An edge appears as a one-cycle tick 3 i_clk cycles after the refclk edge.

Prescalers:
- Three independent counters count ticks 0..DIV-1, one per divider parameter.
- On wrap each emits a one-cycle strobe: stb_1hz, stb_slow, stb_fast.
- set_stb = i_fast_set ? stb_fast : stb_slow.

Run mode (i_set_hours=0 and i_set_minutes=0):
- On stb_1hz, seconds increment.
- 59 wraps to 0 and carries to minutes; minutes 59 carries to hours; hours 23 wraps to 0.
- 23:59:59 -> 00:00:00 in one cycle.

Set mode (either set input high):
- The 1 Hz prescaler and seconds are held at 0.
- On set_stb, hours increment mod 24 if i_set_hours, and minutes increment mod 60 if i_set_minutes.
- There is no carry from minutes into hours in set mode. Both inputs high increments both in the same cycle.
- On leaving set mode, the 1 Hz count restarts from 0, so the first second is a full second.

12-hour format:
- Combinational from registered o_hours.
- o_disp_hours = 12 when o_hours is 0 or 12; o_hours-12 when o_hours > 12; otherwise o_hours.
- Internal count is always 24h. i_mode_12h does not change o_hours.

Alarm:
- Trigger on the run-mode stb_1hz step where the new time equals i_alarm_hours:i_alarm_minutes:00 and i_alarm_en=1.
- Trigger sets o_alarm=1 and loads a second counter with ALARM_SECS.
- The counter decrements on stb_1hz; o_alarm clears when it reaches 0.
- o_alarm also clears on i_alarm_en=0 within 1 cycle.
- No trigger in set mode. A retrigger while active reloads the counter.

Display FSM: states CFG_REQ, TIME_REQ, IDLE.
- After reset, enter CFG_REQ: o_display_stb=1, o_write_config=1, both held until i_display_ack.
- ack in CFG_REQ -> TIME_REQ: next cycle o_display_stb=1, o_write_config=0.
- ack in TIME_REQ -> IDLE: o_display_stb=0 the cycle after ack.
- Update events:
  - stb_1hz in run mode;
  - set_stb in set mode;
  - any edge of i_mode_12h, i_set_hours or i_set_minutes.
- Event in IDLE -> TIME_REQ on the next cycle.
- Event during CFG_REQ or TIME_REQ sets a pending flag; multiple events coalesce into one.
- On ack with pending=1, return to TIME_REQ (stb stays high) and clear pending.
- ack in IDLE is ignored. Output data is never latched by this block: the driver samples the time outputs at its own acceptance.

Test Plan:
Unless noted, benches use REFCLK_DIV=4, SLOW_SET_DIV=8, FAST_SET_DIV=2, ALARM_SECS=3.
1. Reset release with ack returned 2 cycles after each stb -> one config transaction (o_write_config=1), then one time transaction (o_write_config=0), then IDLE with stb=0.
2. Preload 23:59:58 via set mode, then run 8 refclk edges -> 23:59:59 then 00:00:00; o_pm 1 -> 0; one display transaction per second.
3. i_set_hours=1, i_fast_set=1, 48 refclk edges -> hours advance by 24 back to start; minutes and seconds unchanged; seconds=0 throughout.
4. i_mode_12h=1, sweep hours 0, 11, 12, 13, 23 -> o_disp_hours 12, 11, 12, 1, 11; o_pm 0, 0, 1, 1, 1.
5. Alarm at 00:01, i_alarm_en=1, run from 00:00:58 -> o_alarm rises at 00:01:00 and falls at 00:01:03. Repeat with i_alarm_en dropped at 00:01:01 -> clears within 1 cycle.
6. Hold i_display_ack low across 3 stb_1hz ticks in TIME_REQ, then ack -> exactly one further TIME_REQ transaction, then IDLE. Assert i_reset_n low mid-request -> immediate return to reset values, then the FSM restarts at CFG_REQ.
